// File: rtl/execute_muldiv_unit_pkg.sv
// rtl/execute_muldiv_unit_pkg.sv - shared encodings and helpers for the RV32M mul/div unit
package execute_muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic a_is_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/execute_muldiv_unit_if.sv
// rtl/execute_muldiv_unit_if.sv - Execute-stage request/result bundle for the mul/div unit
interface execute_muldiv_unit_if;
    import execute_muldiv_unit_pkg::*;

    logic            clear;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            valid_out;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output clear, start, op, src_a, src_b, rd_in,
        input  busy, valid_out, result, rd_out
    );

    modport slave (
        input  clear, start, op, src_a, src_b, rd_in,
        output busy, valid_out, result, rd_out
    );

endinterface

// File: rtl/execute_muldiv_unit_datapath.sv
// rtl/execute_muldiv_unit_datapath.sv - shared shift register, add/subtract step and sign fix-up
module execute_muldiv_unit_datapath
    import execute_muldiv_unit_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            step,
    input  op_e             op_in,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] final_value
);

    op_e               op_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;

    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    assign neg_a = a_is_signed(op_in) & src_a[XLEN-1];
    assign neg_b = b_is_signed(op_in) & src_b[XLEN-1];
    assign mag_a = neg_a ? -src_a : src_a;
    assign mag_b = neg_b ? -src_b : src_b;

    // Multiply and divide share one register: low half holds multiplier / dividend,
    // high half accumulates the product / partial remainder.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] nxt;

    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    assign mul_next  = {mul_sum, prod[XLEN-1:1]};
    assign div_trial = prod[2*XLEN-1:XLEN-1];
    assign div_diff  = div_trial - {1'b0, mcand};
    assign div_ok    = ~div_diff[XLEN];
    assign div_next  = {div_ok ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0], prod[XLEN-2:0], div_ok};
    assign nxt       = op_is_div(op_q) ? div_next : mul_next;

    // Final value is taken from the post-step register so the top can latch it on the last iteration.
    logic              neg_res;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    assign neg_res    = neg_a_q ^ neg_b_q;
    assign prod_fixed = neg_res ? -nxt : nxt;
    assign quo_fixed  = neg_res ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
    assign rem_fixed  = neg_a_q ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];

    always_comb begin
        final_value = '0;
        case (op_q)
            OP_MUL:                        final_value = prod_fixed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_value = prod_fixed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_value = quo_fixed;
            default:                       final_value = rem_fixed;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            op_q    <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            mcand   <= '0;
            prod    <= '0;
        end else if (load) begin
            op_q    <= op_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            mcand   <= mag_b;
            prod    <= {{XLEN{1'b0}}, mag_a};
        end else if (step) begin
            prod    <= nxt;
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative RV32M multiply/divide unit, FSM and result register
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
(
    input logic                clock,
    input logic                reset,
    execute_muldiv_unit_if.slave bus
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rd_q;
    op_e              op_in;
    logic             accept;
    logic             last;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [XLEN-1:0]  special_value;
    logic [XLEN-1:0]  final_value;

    assign op_in  = op_e'(bus.op);
    assign accept = (state == ST_IDLE) && bus.start;
    assign last   = (cnt == CNT_W'(XLEN - 1));

    // Asserted combinationally on the accept cycle so hazard logic stalls without a bubble.
    assign bus.busy = accept || (state == ST_MUL) || (state == ST_DIV);

    assign div_zero = (bus.src_b == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
    assign special  = op_is_div(op_in) && (div_zero || div_ovf);

    always_comb begin
        special_value = '0;
        if (div_zero)
            special_value = op_is_rem(op_in) ? bus.src_a : '1;
        else
            special_value = op_is_rem(op_in) ? '0 : bus.src_a;
    end

    execute_muldiv_unit_datapath u_datapath (
        .clock       (clock),
        .reset       (reset),
        .flush       (bus.clear),
        .load        (accept),
        .step        ((state == ST_MUL) || (state == ST_DIV)),
        .op_in       (op_in),
        .src_a       (bus.src_a),
        .src_b       (bus.src_b),
        .final_value (final_value)
    );

    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rd_q          <= '0;
            bus.valid_out <= 1'b0;
            bus.result    <= '0;
            bus.rd_out    <= '0;
        end else begin
            bus.valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt  <= '0;
                        rd_q <= bus.rd_in;
                        if (!op_is_div(op_in)) begin
                            state <= ST_MUL;
                        end else if (special) begin
                            state         <= ST_DONE;
                            bus.valid_out <= 1'b1;
                            bus.result    <= special_value;
                            bus.rd_out    <= bus.rd_in;
                        end else begin
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last) begin
                        state         <= ST_DONE;
                        bus.valid_out <= 1'b1;
                        bus.result    <= final_value;
                        bus.rd_out    <= rd_q;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
